// File: rtl/cart_pkg.sv
// cart_pkg: shared types and constants for the cartridge ROM fetch path.
// Optional feature macro: CART_ROM_PREFETCH_EN (next-word prefetch buffer).
package cart_pkg;

  // Byte-address width of the cartridge ROM space.
  localparam int CART_ADDR_W = 25;

  // Fetch FSM states. ST_PREF is only reachable with CART_ROM_PREFETCH_EN.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_PREF = 2'd2
  } fetch_state_e;

  // Pick one byte out of a little-endian 16-bit word (hi=1 -> odd byte).
  function automatic logic [7:0] select_byte(input logic [15:0] word, input logic hi);
    logic [7:0] b;
    if (hi) begin
      b = word[15:8];
    end else begin
      b = word[7:0];
    end
    return b;
  endfunction

endpackage

// File: rtl/cart_rom_fetch_if.sv
// cart_rom_fetch_if: mapper-side read port plus SDRAM word-read port.
// slave = fetch unit view, master = mapper/SDRAM environment view.
// Optional feature macro: CART_ROM_PREFETCH_EN (does not change this bundle).
interface cart_rom_fetch_if
  import cart_pkg::*;
#(
  parameter int ADDR_W = CART_ADDR_W
);
  logic [ADDR_W-1:0] rom_address;
  logic              cart_read;
  logic [7:0]        rom_din;
  logic              rom_busy;
  logic              sdram_req;
  logic [ADDR_W-1:0] sdram_addr;
  logic              sdram_ack;
  logic [15:0]       sdram_data;

  modport slave (
    input  rom_address, cart_read, sdram_ack, sdram_data,
    output rom_din, rom_busy, sdram_req, sdram_addr
  );

  modport master (
    output rom_address, cart_read, sdram_ack, sdram_data,
    input  rom_din, rom_busy, sdram_req, sdram_addr
  );
endinterface

// File: rtl/cart_rom_wordbuf.sv
// cart_rom_wordbuf: one cached 16-bit ROM word with its word tag and valid bit.
// match is combinational against probe_tag. With CART_ROM_PREFETCH_EN the
// stored tag and valid are also exported so two buffers can be swapped.
module cart_rom_wordbuf
  import cart_pkg::*;
#(
  parameter int TAG_W = CART_ADDR_W - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [15:0]      word_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             valid_in,
  input  logic [TAG_W-1:0] probe_tag,
  output logic [15:0]      word,
  output logic             match
`ifdef CART_ROM_PREFETCH_EN
  ,
  output logic [TAG_W-1:0] tag,
  output logic             valid
`endif
);

  logic [15:0]      word_q, word_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             valid_q, valid_d;

  // Capture a new entry on load, otherwise hold
  always_comb begin
    if (load) begin
      word_d  = word_in;
      tag_d   = tag_in;
      valid_d = valid_in;
    end else begin
      word_d  = word_q;
      tag_d   = tag_q;
      valid_d = valid_q;
    end
  end

  // Entry storage; reset only needs to drop valid but clears everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= 16'h0000;
      tag_q   <= {TAG_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

  assign word  = word_q;
  assign match = valid_q && (tag_q == probe_tag);
`ifdef CART_ROM_PREFETCH_EN
  assign tag   = tag_q;
  assign valid = valid_q;
`endif

endmodule

// File: rtl/cart_rom_fetch.sv
// cart_rom_fetch: turns byte reads from the cart mapper into 16-bit SDRAM
// word reads, keeping the last word so the sibling byte hits with no delay.
// Optional feature macro: CART_ROM_PREFETCH_EN adds a second word buffer that
// is filled with the following word after every demand fill.
module cart_rom_fetch
  import cart_pkg::*;
#(
  parameter int                ADDR_W   = CART_ADDR_W,
  parameter logic [ADDR_W-1:0] ROM_BASE = {ADDR_W{1'b0}}
) (
  input logic             clk_sys,
  input logic             reset,
  cart_rom_fetch_if.slave bus
);

  localparam int TAG_W = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] WORD_STEP = {{(ADDR_W-2){1'b0}}, 2'b10};
  localparam logic [TAG_W-1:0]  TAG_ONE   = {{(TAG_W-1){1'b0}}, 1'b1};

  fetch_state_e      state_q, state_d;
  logic              sdram_req_q, sdram_req_d;
  logic [ADDR_W-1:0] sdram_addr_q, sdram_addr_d;
  logic [TAG_W-1:0]  pend_tag_q, pend_tag_d;   // word tag of the fetch in flight
  logic [7:0]        rom_din_q, rom_din_d;

  logic [TAG_W-1:0]  cur_tag_s;
  logic [ADDR_W-1:0] based_addr_s;
  logic              hit_s, miss_s;
  logic [7:0]        byte_s;

  logic              d_load_s, d_valid_in_s, d_match_s;
  logic [15:0]       d_word_in_s, d_word_s;
  logic [TAG_W-1:0]  d_tag_in_s;
`ifdef CART_ROM_PREFETCH_EN
  logic              p_load_s, p_valid_in_s, p_match_s, p_valid_s, d_valid_s;
  logic [15:0]       p_word_in_s, p_word_s;
  logic [TAG_W-1:0]  p_tag_in_s, p_tag_s, d_tag_s;
`endif

  assign cur_tag_s    = bus.rom_address[ADDR_W-1:1];
  assign based_addr_s = bus.rom_address + ROM_BASE;   // wraps modulo 2^ADDR_W
  assign hit_s        = bus.cart_read && d_match_s;
  assign miss_s       = bus.cart_read && !d_match_s;
  assign byte_s       = select_byte(d_word_s, bus.rom_address[0]);

  cart_rom_wordbuf #(.TAG_W(TAG_W)) u_dbuf (
    .clk       (clk_sys),
    .rst       (reset),
    .load      (d_load_s),
    .word_in   (d_word_in_s),
    .tag_in    (d_tag_in_s),
    .valid_in  (d_valid_in_s),
    .probe_tag (cur_tag_s),
    .word      (d_word_s),
    .match     (d_match_s)
`ifdef CART_ROM_PREFETCH_EN
    ,
    .tag       (d_tag_s),
    .valid     (d_valid_s)
`endif
  );

`ifdef CART_ROM_PREFETCH_EN
  cart_rom_wordbuf #(.TAG_W(TAG_W)) u_pbuf (
    .clk       (clk_sys),
    .rst       (reset),
    .load      (p_load_s),
    .word_in   (p_word_in_s),
    .tag_in    (p_tag_in_s),
    .valid_in  (p_valid_in_s),
    .probe_tag (cur_tag_s),
    .word      (p_word_s),
    .match     (p_match_s),
    .tag       (p_tag_s),
    .valid     (p_valid_s)
  );
`endif

  // Next-state, SDRAM request and buffer-load decisions of the fetch FSM
  always_comb begin
    state_d      = state_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    pend_tag_d   = pend_tag_q;
    d_load_s     = 1'b0;
    d_word_in_s  = bus.sdram_data;
    d_tag_in_s   = pend_tag_q;
    d_valid_in_s = 1'b1;
`ifdef CART_ROM_PREFETCH_EN
    p_load_s     = 1'b0;
    p_word_in_s  = bus.sdram_data;
    p_tag_in_s   = pend_tag_q;
    p_valid_in_s = 1'b1;
`endif
    case (state_q)
      ST_IDLE: begin
        if (miss_s) begin
`ifdef CART_ROM_PREFETCH_EN
          if (p_match_s) begin
            // Prefetched word is the one wanted: exchange the two buffers
            d_load_s     = 1'b1;
            d_word_in_s  = p_word_s;
            d_tag_in_s   = p_tag_s;
            d_valid_in_s = p_valid_s;
            p_load_s     = 1'b1;
            p_word_in_s  = d_word_s;
            p_tag_in_s   = d_tag_s;
            p_valid_in_s = d_valid_s;
          end else begin
            state_d      = ST_REQ;
            sdram_req_d  = 1'b1;
            sdram_addr_d = {based_addr_s[ADDR_W-1:1], 1'b0};
            pend_tag_d   = cur_tag_s;
          end
`else
          state_d      = ST_REQ;
          sdram_req_d  = 1'b1;
          sdram_addr_d = {based_addr_s[ADDR_W-1:1], 1'b0};
          pend_tag_d   = cur_tag_s;
`endif
        end else begin
          state_d = ST_IDLE;   // acks seen here are stale and ignored
        end
      end
      ST_REQ: begin
        if (bus.sdram_ack) begin
          d_load_s = 1'b1;
`ifdef CART_ROM_PREFETCH_EN
          // Immediately chase the following word; SDRAM offset steps by 2
          state_d      = ST_PREF;
          sdram_req_d  = 1'b1;
          sdram_addr_d = sdram_addr_q + WORD_STEP;
          pend_tag_d   = pend_tag_q + TAG_ONE;
`else
          state_d     = ST_IDLE;
          sdram_req_d = 1'b0;
`endif
        end else begin
          state_d = ST_REQ;
        end
      end
`ifdef CART_ROM_PREFETCH_EN
      ST_PREF: begin
        if (bus.sdram_ack) begin
          p_load_s    = 1'b1;
          state_d     = ST_IDLE;
          sdram_req_d = 1'b0;
        end else begin
          state_d = ST_PREF;
        end
      end
`endif
      default: begin
        state_d     = ST_IDLE;
        sdram_req_d = 1'b0;
      end
    endcase
  end

  // Output byte: live buffer byte on a hit, otherwise the last byte delivered
  always_comb begin
    if (hit_s) begin
      rom_din_d = byte_s;
    end else begin
      rom_din_d = rom_din_q;
    end
  end

  // Fetch FSM state and registered SDRAM request outputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= {ADDR_W{1'b0}};
      pend_tag_q   <= {TAG_W{1'b0}};
      rom_din_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      pend_tag_q   <= pend_tag_d;
      rom_din_q    <= rom_din_d;
    end
  end

  assign bus.rom_din    = rom_din_d;
  assign bus.rom_busy   = miss_s && !reset;
  assign bus.sdram_req  = sdram_req_q;
  assign bus.sdram_addr = sdram_addr_q;

endmodule

// File: tb/tb_cart_rom_fetch.sv
// tb_cart_rom_fetch: directed checks of cart_rom_fetch. dut0 uses ROM_BASE 0,
// dut1 uses ROM_BASE 25'h10000. Build with CART_ROM_PREFETCH_EN to exercise
// the prefetch buffer sequence instead of the plain demand sequence.
module tb_cart_rom_fetch;
  import cart_pkg::*;

  localparam int AW = CART_ADDR_W;

  logic clk_sys = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_cnt;

  always #5 clk_sys = ~clk_sys;

  cart_rom_fetch_if #(.ADDR_W(AW)) bus0 ();
  cart_rom_fetch_if #(.ADDR_W(AW)) bus1 ();

  cart_rom_fetch #(.ADDR_W(AW), .ROM_BASE(25'h0000000)) dut0 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus0)
  );

  cart_rom_fetch #(.ADDR_W(AW), .ROM_BASE(25'h0010000)) dut1 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge (input drive point)
  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  // Sampling point, half a period away from the active edge
  task automatic smp();
    @(negedge clk_sys);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus0.rom_address = 25'h0000000; bus0.cart_read = 1'b1;
    bus0.sdram_ack = 1'b0;          bus0.sdram_data = 16'h0000;
    bus1.rom_address = 25'h0000000; bus1.cart_read = 1'b0;
    bus1.sdram_ack = 1'b0;          bus1.sdram_data = 16'h0000;

    // Reset: read strobe high but busy must stay low, outputs cleared
    smp();
    chk("rst_busy", 32'(bus0.rom_busy), 32'd0);
    chk("rst_req",  32'(bus0.sdram_req), 32'd0);
    chk("rst_addr", 32'(bus0.sdram_addr), 32'h0000000);
    chk("rst_din",  32'(bus0.rom_din), 32'h00);
    cyc(); smp();
    chk("rst_busy_clk", 32'(bus0.rom_busy), 32'd0);
    chk("rst_req_clk",  32'(bus0.sdram_req), 32'd0);
    cyc(); reset = 1'b0; bus0.cart_read = 1'b0;

`ifndef CART_ROM_PREFETCH_EN
    // Demand miss on 0x0, ack three cycles later with 0xBEEF
    cyc(); bus0.rom_address = 25'h0000000; bus0.cart_read = 1'b1; busy_cnt = 0;
    smp(); busy_cnt += int'(bus0.rom_busy);
    chk("a_c0_busy", 32'(bus0.rom_busy), 32'd1);
    chk("a_c0_req",  32'(bus0.sdram_req), 32'd0);
    cyc(); smp(); busy_cnt += int'(bus0.rom_busy);
    chk("a_req_up", 32'(bus0.sdram_req), 32'd1);
    chk("a_addr",   32'(bus0.sdram_addr), 32'h0000000);
    cyc(); smp(); busy_cnt += int'(bus0.rom_busy);
    chk("a_req_hold", 32'(bus0.sdram_req), 32'd1);
    cyc(); bus0.sdram_ack = 1'b1; bus0.sdram_data = 16'hBEEF;
    smp(); busy_cnt += int'(bus0.rom_busy);
    chk("a_ack_busy", 32'(bus0.rom_busy), 32'd1);
    cyc(); bus0.sdram_ack = 1'b0; bus0.sdram_data = 16'h0000;
    smp(); busy_cnt += int'(bus0.rom_busy);
    chk("a_busy_cycles", 32'(busy_cnt), 32'd4);
    chk("a_din_even", 32'(bus0.rom_din), 32'hEF);
    chk("a_req_drop", 32'(bus0.sdram_req), 32'd0);
    cyc(); bus0.rom_address = 25'h0000001;
    smp();
    chk("a_odd_busy", 32'(bus0.rom_busy), 32'd0);
    chk("a_odd_din",  32'(bus0.rom_din), 32'hBE);
    cyc(); smp();
    chk("a_no_new_req", 32'(bus0.sdram_req), 32'd0);
    cyc(); bus0.cart_read = 1'b0; bus0.rom_address = 25'h0000040;
    smp();
    chk("a_din_hold", 32'(bus0.rom_din), 32'hBE);
    chk("a_idle_busy", 32'(bus0.rom_busy), 32'd0);

    // Spurious ack in IDLE must not touch the buffer or rom_din
    cyc(); bus0.sdram_ack = 1'b1; bus0.sdram_data = 16'h1234;
    smp();
    chk("b_spur_req", 32'(bus0.sdram_req), 32'd0);
    chk("b_spur_din", 32'(bus0.rom_din), 32'hBE);
    cyc(); bus0.sdram_ack = 1'b0; bus0.sdram_data = 16'h0000;
    bus0.cart_read = 1'b1; bus0.rom_address = 25'h0000000;
    smp();
    chk("b_hit_busy", 32'(bus0.rom_busy), 32'd0);
    chk("b_hit_din",  32'(bus0.rom_din), 32'hEF);

    // Address change during REQ: first fetch completes, then 0x200 fetched
    cyc(); bus0.rom_address = 25'h0000100;
    smp();
    chk("c_miss_busy", 32'(bus0.rom_busy), 32'd1);
    cyc(); bus0.rom_address = 25'h0000200;
    smp();
    chk("c_req1",  32'(bus0.sdram_req), 32'd1);
    chk("c_addr1", 32'(bus0.sdram_addr), 32'h0000100);
    cyc(); bus0.sdram_ack = 1'b1; bus0.sdram_data = 16'hA55A;
    smp();
    chk("c_addr1_stable", 32'(bus0.sdram_addr), 32'h0000100);
    cyc(); bus0.sdram_ack = 1'b0;
    smp();
    chk("c_idle_req", 32'(bus0.sdram_req), 32'd0);
    chk("c_idle_busy", 32'(bus0.rom_busy), 32'd1);
    cyc(); smp();
    chk("c_req2",  32'(bus0.sdram_req), 32'd1);
    chk("c_addr2", 32'(bus0.sdram_addr), 32'h0000200);
    cyc(); bus0.sdram_ack = 1'b1; bus0.sdram_data = 16'h7711;
    smp();
    cyc(); bus0.sdram_ack = 1'b0;
    smp();
    chk("c_hit2_busy", 32'(bus0.rom_busy), 32'd0);
    chk("c_hit2_din",  32'(bus0.rom_din), 32'h11);
    cyc(); bus0.rom_address = 25'h0000100;
    smp();
    chk("c_old_miss", 32'(bus0.rom_busy), 32'd1);
    cyc(); bus0.cart_read = 1'b0;
    smp();
    chk("c_refetch_addr", 32'(bus0.sdram_addr), 32'h0000100);
    cyc(); bus0.sdram_ack = 1'b1; bus0.sdram_data = 16'hA55A;
    smp();
    cyc(); bus0.sdram_ack = 1'b0; bus0.cart_read = 1'b1; bus0.rom_address = 25'h0000101;
    smp();
    chk("c_refetch_din", 32'(bus0.rom_din), 32'hA5);

    // Reset in the middle of a fetch, ack arriving after release
    cyc(); bus0.rom_address = 25'h0000300;
    smp();
    chk("d_miss", 32'(bus0.rom_busy), 32'd1);
    cyc(); smp();
    chk("d_req", 32'(bus0.sdram_req), 32'd1);
    cyc(); reset = 1'b1;
    smp();
    chk("d_rst_req",  32'(bus0.sdram_req), 32'd0);
    chk("d_rst_addr", 32'(bus0.sdram_addr), 32'h0000000);
    chk("d_rst_busy", 32'(bus0.rom_busy), 32'd0);
    chk("d_rst_din",  32'(bus0.rom_din), 32'h00);
    cyc(); reset = 1'b0; bus0.sdram_ack = 1'b1; bus0.sdram_data = 16'hFFFF; bus0.cart_read = 1'b0;
    smp();
    chk("d_late_ack_req", 32'(bus0.sdram_req), 32'd0);
    cyc(); bus0.sdram_ack = 1'b0; bus0.cart_read = 1'b1; bus0.rom_address = 25'h0000300;
    smp();
    chk("d_still_miss", 32'(bus0.rom_busy), 32'd1);
    chk("d_din_zero",   32'(bus0.rom_din), 32'h00);
    cyc(); smp();
    chk("d_new_req", 32'(bus0.sdram_req), 32'd1);
    cyc(); bus0.sdram_ack = 1'b1; bus0.sdram_data = 16'h0102;
    smp();
    cyc(); bus0.sdram_ack = 1'b0;
    smp();
    chk("d_fill_din", 32'(bus0.rom_din), 32'h02);
    cyc(); bus0.cart_read = 1'b0;

    // ROM_BASE offset and silent wrap at the top of the space
    cyc(); bus1.cart_read = 1'b1; bus1.rom_address = 25'h0000123;
    smp();
    chk("e_busy", 32'(bus1.rom_busy), 32'd1);
    cyc(); smp();
    chk("e_req",  32'(bus1.sdram_req), 32'd1);
    chk("e_addr", 32'(bus1.sdram_addr), 32'h0010122);
    cyc(); bus1.sdram_ack = 1'b1; bus1.sdram_data = 16'h9988;
    smp();
    cyc(); bus1.sdram_ack = 1'b0;
    smp();
    chk("e_din", 32'(bus1.rom_din), 32'h99);
    cyc(); bus1.rom_address = 25'h1FF0005;
    smp();
    chk("e_wrap_busy", 32'(bus1.rom_busy), 32'd1);
    cyc(); smp();
    chk("e_wrap_addr", 32'(bus1.sdram_addr), 32'h0000004);
    cyc(); bus1.sdram_ack = 1'b1; bus1.sdram_data = 16'h4433;
    smp();
    cyc(); bus1.sdram_ack = 1'b0;
    smp();
    chk("e_wrap_din", 32'(bus1.rom_din), 32'h44);
    cyc(); bus1.cart_read = 1'b0;
`else
    // Demand fill of the top word, prefetch wraps to word 0
    cyc(); bus0.rom_address = 25'h1FFFFFE; bus0.cart_read = 1'b1;
    smp();
    chk("p_miss", 32'(bus0.rom_busy), 32'd1);
    cyc(); smp();
    chk("p_dreq_addr", 32'(bus0.sdram_addr), 32'h1FFFFFE);
    cyc(); bus0.sdram_ack = 1'b1; bus0.sdram_data = 16'h2211;
    smp();
    cyc(); bus0.sdram_ack = 1'b0;
    smp();
    chk("p_hit_busy", 32'(bus0.rom_busy), 32'd0);
    chk("p_hit_din",  32'(bus0.rom_din), 32'h11);
    chk("p_pref_req", 32'(bus0.sdram_req), 32'd1);
    chk("p_pref_addr", 32'(bus0.sdram_addr), 32'h0000000);
    cyc(); bus0.sdram_ack = 1'b1; bus0.sdram_data = 16'h6655;
    smp();
    cyc(); bus0.sdram_ack = 1'b0; bus0.rom_address = 25'h0000000; busy_cnt = 0;
    smp(); busy_cnt += int'(bus0.rom_busy);
    chk("p_swap_req", 32'(bus0.sdram_req), 32'd0);
    cyc(); smp(); busy_cnt += int'(bus0.rom_busy);
    chk("p_swap_busy_total", 32'(busy_cnt), 32'd1);
    chk("p_swap_din", 32'(bus0.rom_din), 32'h55);
    chk("p_swap_noreq", 32'(bus0.sdram_req), 32'd0);
    cyc(); bus0.rom_address = 25'h1FFFFFF;
    smp();
    chk("p_back_busy", 32'(bus0.rom_busy), 32'd1);
    cyc(); smp();
    chk("p_back_din", 32'(bus0.rom_din), 32'h22);
    chk("p_back_noreq", 32'(bus0.sdram_req), 32'd0);
    cyc(); bus0.cart_read = 1'b0; bus0.sdram_ack = 1'b1; bus0.sdram_data = 16'h1234;
    smp();
    chk("p_spur_req", 32'(bus0.sdram_req), 32'd0);
    cyc(); bus0.sdram_ack = 1'b0; bus0.cart_read = 1'b1; bus0.rom_address = 25'h1FFFFFE;
    smp();
    chk("p_spur_busy", 32'(bus0.rom_busy), 32'd0);
    chk("p_spur_din",  32'(bus0.rom_din), 32'h11);
    cyc(); bus0.cart_read = 1'b0;
`endif

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
